// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the ALUOp class.
module mips_main_control_fsm #(
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  logic w_legal;
  assign w_legal = (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_RTYP) || (opcode == OP_BEQ) ||
                   (opcode == OP_ADDI) || (opcode == OP_J);

  // Reset overrides everything so no enable can fire during an abort.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state      = 4'd0;
    if (!reset) begin
      state = r_state;
      unique case (r_state)
        S_FETCH: begin
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !w_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPEEX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FN;
        end
        S_RTYPEWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQEX: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = 2'b01;
          branch     = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JEX: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Directed per-cycle vector bench for the multicycle MIPS main control FSM.
module tb_mips_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  mips_main_control_fsm #(.ALUOP_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {pw,br,iord,mw,irw,m2r,rdst,rw,asa, asb[2], pcs[2], aop[3], done, ill}
  localparam logic [17:0] Z       = 18'b000000000_00_00_000_00;
  localparam logic [17:0] FET_R   = 18'b100010000_01_00_000_00;
  localparam logic [17:0] FET_W   = 18'b000000000_01_00_000_00;
  localparam logic [17:0] DEC     = 18'b000000000_11_00_000_00;
  localparam logic [17:0] DEC_ILL = 18'b000000000_11_00_000_01;
  localparam logic [17:0] MEMADR  = 18'b000000001_10_00_000_00;
  localparam logic [17:0] MEMRD   = 18'b001000000_00_00_000_00;
  localparam logic [17:0] MEMWB   = 18'b000001010_00_00_000_10;
  localparam logic [17:0] MEMWR_W = 18'b001100000_00_00_000_00;
  localparam logic [17:0] MEMWR_R = 18'b001100000_00_00_000_10;
  localparam logic [17:0] RTEX    = 18'b000000001_00_00_010_00;
  localparam logic [17:0] RTWB    = 18'b000000110_00_00_000_10;
  localparam logic [17:0] BEQ     = 18'b010000001_00_01_001_10;
  localparam logic [17:0] ADDIWB  = 18'b000000010_00_00_000_10;
  localparam logic [17:0] JEX     = 18'b100000000_00_10_000_10;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AD = 6'b001000, JJ = 6'b000010;
  localparam logic [5:0] IL = 6'b111111;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [17:0] outs();
    return {pc_write, branch, iord, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op,
            instr_done, illegal_op};
  endfunction

  task automatic add(input string n, input logic r, input logic [5:0] o,
                     input logic m, input logic [3:0] s,
                     input logic [17:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.mr = m; v.st = s; v.out = e;
    vecs.push_back(v);
  endtask

  // Drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input string n, input logic r, input logic [5:0] o,
                      input logic m, input logic [3:0] s,
                      input logic [17:0] e);
    reset = r; opcode = o; mem_ready = m;
    @(negedge clk);
    checks++;
    if (state !== s) begin
      failures++;
      $display("FAIL %s state: got %0d want %0d", n, state, s);
    end
    checks++;
    if (outs() !== e) begin
      failures++;
      $display("FAIL %s outputs: got %b want %b", n, outs(), e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    add("rst0", 1, RT, 1, 0, Z);
    add("rst1", 1, RT, 1, 0, Z);
    add("rt_f", 0, RT, 1, 0, FET_R);
    add("rt_d", 0, RT, 1, 1, DEC);
    add("rt_ex", 0, JJ, 1, 6, RTEX);
    add("rt_wb", 0, JJ, 1, 7, RTWB);
    add("lw_f", 0, LW, 1, 0, FET_R);
    add("lw_d", 0, LW, 1, 1, DEC);
    add("lw_a", 0, LW, 1, 2, MEMADR);
    add("lw_rd0", 0, LW, 0, 3, MEMRD);
    add("lw_rd1", 0, LW, 0, 3, MEMRD);
    add("lw_rd2", 0, LW, 1, 3, MEMRD);
    add("lw_wb", 0, LW, 1, 4, MEMWB);
    add("sw_f", 0, SW, 1, 0, FET_R);
    add("sw_d", 0, SW, 1, 1, DEC);
    add("sw_a", 0, SW, 1, 2, MEMADR);
    add("sw_wr", 0, SW, 1, 5, MEMWR_R);
    add("sw2_f", 0, SW, 1, 0, FET_R);
    add("sw2_d", 0, SW, 1, 1, DEC);
    add("sw2_a", 0, SW, 1, 2, MEMADR);
    add("sw2_w0", 0, SW, 0, 5, MEMWR_W);
    add("sw2_w1", 0, SW, 1, 5, MEMWR_R);
    add("beq_f", 0, BQ, 1, 0, FET_R);
    add("beq_d", 0, BQ, 1, 1, DEC);
    add("beq_ex", 0, BQ, 1, 8, BEQ);
    add("ill_f", 0, IL, 1, 0, FET_R);
    add("ill_d", 0, IL, 1, 1, DEC_ILL);
    add("j_f", 0, JJ, 1, 0, FET_R);
    add("j_d", 0, JJ, 1, 1, DEC);
    add("j_ex", 0, JJ, 1, 11, JEX);
    add("ad_f", 0, AD, 1, 0, FET_R);
    add("ad_d", 0, AD, 1, 1, DEC);
    add("ad_ex", 0, LW, 1, 9, MEMADR);
    add("ad_wb", 0, IL, 1, 10, ADDIWB);
    add("fw0", 0, RT, 0, 0, FET_W);
    add("fw1", 0, RT, 0, 0, FET_W);
    add("fw2", 0, RT, 0, 0, FET_W);
    add("fw3", 0, RT, 1, 0, FET_R);
    add("fw_d", 0, RT, 1, 1, DEC);
    add("fw_ex", 0, RT, 1, 6, RTEX);
    add("fw_wb", 0, RT, 1, 7, RTWB);

    reset = 1'b1; opcode = RT; mem_ready = 1'b1;
    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].mr,
           vecs[i].st, vecs[i].out);

    // lw aborted by reset while waiting in MEMRD
    step("ab_f", 0, LW, 1, 0, FET_R);
    step("ab_d", 0, LW, 1, 1, DEC);
    step("ab_a", 0, LW, 1, 2, MEMADR);
    step("ab_rd", 0, LW, 0, 3, MEMRD);
    step("ab_rst", 1, LW, 1, 0, Z);
    step("ab_f2", 0, SW, 1, 0, FET_R);
    // sw aborted by reset while mem_write is held in MEMWR
    step("ab_d2", 0, SW, 1, 1, DEC);
    step("ab_a2", 0, SW, 1, 2, MEMADR);
    step("ab_w2", 0, SW, 0, 5, MEMWR_W);
    step("ab_rst2", 1, SW, 0, 0, Z);
    step("ab_f3", 0, SW, 0, 0, FET_W);
    step("ab_f4", 0, BQ, 1, 0, FET_R);
    step("ab_d4", 0, BQ, 1, 1, DEC);
    step("ab_b4", 0, BQ, 1, 8, BEQ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
